// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/bubble controller
// and the hazard logic that the forwarding unit will reuse.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    SELF_SEQ = 2'd2,
    HALT     = 2'd3
  } ctrl_state_e;

  localparam logic [3:0]  REG_PC    = 4'd15;
  localparam logic [15:0] NOP_INSTR = 16'b1111;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator: a load in execute whose
// destination is read by the instruction in decode.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_mem2reg,
  input  logic       ex_wr_en,
  input  logic       instr_valid,
  input  logic [3:0] ex_wr_sel,
  input  logic [3:0] rd0_sel,
  input  logic [3:0] rd1_sel,
  output logic       lu
);

  logic src_match;

  // The PC is always current in decode, so it can never be a stale source.
  assign src_match = (ex_wr_sel != REG_PC) &&
                     ((ex_wr_sel == rd0_sel) || (ex_wr_sel == rd1_sel));

  assign lu = ex_mem2reg & ex_wr_en & instr_valid & src_match;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/bubble scheduler: sequences memory waits, micro-op
// sequences, load-use bubbles and program end for the 16-bit pipeline.
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 15,
  parameter int MAX_SELF_STEPS = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  input  logic       dec_mem_load_i,
  input  logic       dec_mem_write_i,
  input  logic       dec_self_instr_i,
  input  logic       dec_end_program_i,
  input  logic [3:0] dec_rd0_sel_i,
  input  logic [3:0] dec_rd1_sel_i,
  input  logic [3:0] ex_wr_sel_i,
  input  logic       ex_wr_en_i,
  input  logic       ex_mem2reg_i,
  input  logic       mem_ready_i,
  output logic       fetch_stall_o,
  output logic       decode_stall_o,
  output logic       ex_bubble_o,
  output logic       halted_o,
  output logic       error_o,
  output logic [1:0] state_o
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
  localparam logic [3:0] STEP_LIMIT = 4'(MAX_SELF_STEPS);

  ctrl_state_e state, state_n;
  logic [7:0]  wait_cnt, wait_n;
  logic [3:0]  step_cnt, step_n;
  logic        ret_self, ret_n;
  logic        halted, halted_n;
  logic        error, error_n;
  logic        lu_raw, lu, issue, active;

  load_use_detect u_lu (
    .ex_mem2reg  (ex_mem2reg_i),
    .ex_wr_en    (ex_wr_en_i),
    .instr_valid (instr_valid_i),
    .ex_wr_sel   (ex_wr_sel_i),
    .rd0_sel     (dec_rd0_sel_i),
    .rd1_sel     (dec_rd1_sel_i),
    .lu          (lu_raw)
  );

  // Mealy terms are suppressed while reset is held low.
  assign active = (state == RUN) || (state == SELF_SEQ);
  assign lu     = lu_raw & active & rst_i;
  assign issue  = active & instr_valid_i & !lu & (dec_mem_load_i | dec_mem_write_i);

  always_comb begin
    state_n  = state;
    wait_n   = wait_cnt;
    step_n   = step_cnt;
    ret_n    = ret_self;
    halted_n = halted;
    error_n  = error;
    if (dec_end_program_i && instr_valid_i && state != HALT) begin
      state_n  = HALT;
      halted_n = 1'b1;
    end else if (issue) begin
      state_n = MEM_WAIT;
      ret_n   = (state == SELF_SEQ) | dec_self_instr_i;
      wait_n  = 8'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (dec_self_instr_i && !lu) begin
            state_n = SELF_SEQ;
            step_n  = 4'd1;
          end
        end
        SELF_SEQ: begin
          if (!dec_self_instr_i) begin
            state_n = RUN;
            step_n  = 4'd0;
          end else if (step_cnt == STEP_LIMIT) begin
            state_n = RUN;
            error_n = 1'b1;
            step_n  = 4'd0;
          end else if (step_cnt != 4'hF) begin
            step_n = step_cnt + 4'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ready_i) begin
            state_n = ret_self ? SELF_SEQ : RUN;
            ret_n   = 1'b0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_n = RUN;
            error_n = 1'b1;
            ret_n   = 1'b0;
          end else if (wait_cnt != 8'hFF) begin
            wait_n = wait_cnt + 8'd1;
          end
        end
        HALT: ;
        default: state_n = RUN;
      endcase
    end
  end

  always_comb begin
    fetch_stall_o  = 1'b0;
    decode_stall_o = 1'b0;
    ex_bubble_o    = 1'b0;
    if (rst_i) begin
      unique case (state)
        RUN: begin
          fetch_stall_o  = lu | dec_self_instr_i;
          decode_stall_o = lu;
          ex_bubble_o    = lu;
        end
        MEM_WAIT: begin
          fetch_stall_o  = 1'b1;
          decode_stall_o = 1'b1;
        end
        SELF_SEQ: begin
          fetch_stall_o  = 1'b1;
          decode_stall_o = lu;
          ex_bubble_o    = lu;
        end
        HALT: begin
          fetch_stall_o  = 1'b1;
          decode_stall_o = 1'b1;
          ex_bubble_o    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      step_cnt <= 4'd0;
      ret_self <= 1'b0;
      halted   <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      step_cnt <= step_n;
      ret_self <= ret_n;
      halted   <= halted_n;
      error    <= error_n;
    end
  end

  assign halted_o = halted;
  assign error_o  = error;
  assign state_o  = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: a table of RUN-state hazard
// vectors followed by multi-cycle sequences for memory, micro-ops and halt.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, mem_load, mem_write, self_instr, end_program;
  logic [3:0] rd0_sel, rd1_sel, ex_wr_sel;
  logic       ex_wr_en, ex_mem2reg, mem_ready;
  logic       fetch_stall, decode_stall, ex_bubble, halted, error;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .MAX_SELF_STEPS(8)) dut (
    .clk_i             (clk),
    .rst_i             (rst_n),
    .instr_valid_i     (instr_valid),
    .dec_mem_load_i    (mem_load),
    .dec_mem_write_i   (mem_write),
    .dec_self_instr_i  (self_instr),
    .dec_end_program_i (end_program),
    .dec_rd0_sel_i     (rd0_sel),
    .dec_rd1_sel_i     (rd1_sel),
    .ex_wr_sel_i       (ex_wr_sel),
    .ex_wr_en_i        (ex_wr_en),
    .ex_mem2reg_i      (ex_mem2reg),
    .mem_ready_i       (mem_ready),
    .fetch_stall_o     (fetch_stall),
    .decode_stall_o    (decode_stall),
    .ex_bubble_o       (ex_bubble),
    .halted_o          (halted),
    .error_o           (error),
    .state_o           (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid, load, write, self_r;
    logic [3:0] rd0, rd1, exs;
    logic       exw, exm;
    logic [2:0] exp_fdb;
  } vec_t;

  vec_t vecs[11];

  // Packed view: {fetch, decode, bubble, halted, error, state[1:0]}
  task automatic chk(input string name, input logic [6:0] want);
    logic [6:0] got;
    got = {fetch_stall, decode_stall, ex_bubble, halted, error, state};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got f/d/b/h/e/st=%b required %b", name, got, want);
    end
  endtask

  task automatic idle();
    instr_valid = 0; mem_load = 0; mem_write = 0; self_instr = 0; end_program = 0;
    rd0_sel = 0; rd1_sel = 0; ex_wr_sel = 0; ex_wr_en = 0; ex_mem2reg = 0; mem_ready = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    vecs[0]  = '{0,0,0,0, 4'd0, 4'd0, 4'd0, 0,0, 3'b000};
    vecs[1]  = '{1,0,0,0, 4'd2, 4'd0, 4'd2, 1,1, 3'b111};
    vecs[2]  = '{1,0,0,0, 4'd5, 4'd2, 4'd2, 1,1, 3'b111};
    vecs[3]  = '{1,0,0,0, 4'd3, 4'd15,4'd2, 1,1, 3'b000};
    vecs[4]  = '{1,0,0,0, 4'd15,4'd15,4'd15,1,1, 3'b000};
    vecs[5]  = '{1,0,0,0, 4'd2, 4'd0, 4'd2, 1,0, 3'b000};
    vecs[6]  = '{1,0,0,0, 4'd2, 4'd0, 4'd2, 0,1, 3'b000};
    vecs[7]  = '{0,0,0,0, 4'd2, 4'd0, 4'd2, 1,1, 3'b000};
    vecs[8]  = '{1,0,0,1, 4'd0, 4'd0, 4'd0, 0,0, 3'b100};
    vecs[9]  = '{1,0,0,1, 4'd7, 4'd1, 4'd7, 1,1, 3'b111};
    vecs[10] = '{1,1,0,0, 4'd4, 4'd4, 4'd4, 1,1, 3'b111};

    // Reset held with hazard and self request present: everything gated to 0.
    idle();
    rst_n = 1'b0;
    instr_valid = 1; self_instr = 1; ex_mem2reg = 1; ex_wr_en = 1;
    ex_wr_sel = 4'd2; rd0_sel = 4'd2;
    #2 chk("reset_state", 7'b0000000);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 11; i++) begin
      instr_valid = vecs[i].valid; mem_load = vecs[i].load; mem_write = vecs[i].write;
      self_instr = vecs[i].self_r; rd0_sel = vecs[i].rd0; rd1_sel = vecs[i].rd1;
      ex_wr_sel = vecs[i].exs; ex_wr_en = vecs[i].exw; ex_mem2reg = vecs[i].exm;
      #1 chk($sformatf("run_vec%0d", i), {vecs[i].exp_fdb, 4'b0000});
      idle();
      cyc();
    end

    // Load-use lasts one cycle: the bubble puts a NOP in EX next cycle.
    instr_valid = 1; ex_mem2reg = 1; ex_wr_en = 1; ex_wr_sel = 4'd2; rd0_sel = 4'd2;
    #1 chk("lu_cycle0", 7'b1110000);
    cyc();
    ex_mem2reg = 0; ex_wr_en = 0; ex_wr_sel = 4'd0;
    #1 chk("lu_cycle1", 7'b0000000);
    idle();
    cyc();

    // Store with ready in the issue cycle (ignored) and again 3 cycles later.
    instr_valid = 1; mem_write = 1; mem_ready = 1;
    #1 chk("store_issue", 7'b0000000);
    cyc(); idle();
    #1 chk("store_wait1", 7'b1100001);
    cyc();
    #1 chk("store_wait2", 7'b1100001);
    cyc(); mem_ready = 1;
    #1 chk("store_wait3", 7'b1100001);
    cyc(); mem_ready = 0;
    #1 chk("store_done", 7'b0000000);

    // Memory timeout with MEM_TIMEOUT=4.
    do_reset();
    instr_valid = 1; mem_load = 1;
    #1 chk("tmo_issue", 7'b0000000);
    for (int k = 1; k <= 4; k++) begin
      cyc(); idle();
      #1 chk($sformatf("tmo_wait%0d", k), 7'b1100001);
    end
    cyc();
    #1 chk("tmo_abort", 7'b0000100);

    // Three micro-ops with a store in step 2.
    do_reset();
    instr_valid = 1; self_instr = 1;
    #1 chk("seq_run", 7'b1000000);
    cyc(); mem_write = 1;
    #1 chk("seq_self_store", 7'b1000010);
    cyc(); idle(); mem_ready = 1;
    #1 chk("seq_memwait", 7'b1100001);
    cyc(); idle(); instr_valid = 1;
    #1 chk("seq_self_last", 7'b1000010);
    cyc(); idle();
    #1 chk("seq_back_run", 7'b0000000);

    // Self request held for 10 cycles: overflow after step 8.
    do_reset();
    instr_valid = 1; self_instr = 1;
    #1 chk("ovf_step0", 7'b1000000);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      #1 chk($sformatf("ovf_step%0d", k), 7'b1000010);
    end
    cyc();
    #1 chk("ovf_abort", 7'b1000100);
    idle();

    // End-of-program together with ready in MEM_WAIT, then async reset.
    do_reset();
    instr_valid = 1; mem_write = 1;
    #1 chk("halt_issue", 7'b0000000);
    cyc(); idle(); instr_valid = 1; end_program = 1; mem_ready = 1;
    #1 chk("halt_memwait", 7'b1100001);
    cyc(); idle();
    #1 chk("halt_entered", 7'b1111011);
    cyc();
    #1 chk("halt_sticky", 7'b1111011);
    #2 rst_n = 1'b0;
    #1 chk("halt_async_reset", 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    #1 chk("post_reset_run", 7'b0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
